fetch_queue: RTL

//  Decouples IF from ID. Tracks in-order instruction-memory reads issued by IF
//  and pairs each returning inst_rdata with the PC that requested it. Buffers
//  {pc, inst} packets and presents them to ID under a valid/ready handshake.

---
 rtl/fetch_queue_pkg.sv | 13 +
 rtl/fetch_queue_fifo_sync.sv | 63 ++++++
 rtl/fetch_queue.sv | 102 ++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue slice.
//   rv32i_word  : 32-bit RV32I datum (PC or instruction word)
//   fetch_pkt_t : {pc, inst} packet handed from fetch to decode
package fetch_queue_pkg;

    typedef logic [31:0] rv32i_word;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word inst;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue_fifo_sync.sv
// fifo_sync: count-based circular buffer, synchronous push/pop with clear.
//   clk, rst      : clock, asynchronous active-low reset
//   clear         : empty the buffer (overrides push/pop)
//   push, push_data
//   pop, pop_data : pop_data is the current head, valid while !empty
//   full, empty, count
module fifo_sync #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (cnt == CNT_W'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: pairs in-order imem responses with their requesting PC and
// buffers {pc, inst} packets for decode under valid/ready.
//   clk, rst             : clock, asynchronous active-low reset
//   req_fire, req_pc     : IF issued an imem read for req_pc
//   inst_resp, inst_rdata: imem returned the oldest outstanding read
//   flush                : EX redirect; squash buffered and in-flight fetches
//   req_allow            : IF may issue another read
//   id_ready / id_valid, id_pc, id_inst : decode handshake on the head packet
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      req_fire,
    input  rv32i_word req_pc,
    input  logic      inst_resp,
    input  rv32i_word inst_rdata,
    input  logic      flush,
    output logic      req_allow,
    input  logic      id_ready,
    output logic      id_valid,
    output rv32i_word id_pc,
    output rv32i_word id_inst
);

    localparam int unsigned BUF_CW  = $clog2(DEPTH + 1);
    localparam int unsigned PEND_CW = $clog2(MAX_OUTST + 1);

    logic [BUF_CW-1:0]  buf_count;
    logic [PEND_CW-1:0] pend_count;
    logic [PEND_CW-1:0] squash_cnt;
    logic [PEND_CW:0]   outst_next;
    logic               buf_full, buf_empty, pend_full, pend_empty;
    logic               buf_push, buf_pop;
    rv32i_word          pend_pc;
    fetch_pkt_t         wr_pkt, head_pkt;

    // Pending-PC queue is never cleared by flush so responses stay paired.
    fifo_sync #(.WIDTH(32), .DEPTH(MAX_OUTST)) u_pend_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (1'b0),
        .push      (req_fire),
        .push_data (req_pc),
        .pop       (inst_resp),
        .pop_data  (pend_pc),
        .full      (pend_full),
        .empty     (pend_empty),
        .count     (pend_count)
    );

    assign buf_push = inst_resp && !flush && (squash_cnt == '0);
    assign buf_pop  = id_valid && id_ready && !flush;
    assign wr_pkt   = '{pc: pend_pc, inst: inst_rdata};

    fifo_sync #(.WIDTH(64), .DEPTH(DEPTH)) u_pkt_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (buf_push),
        .push_data (wr_pkt),
        .pop       (buf_pop),
        .pop_data  (head_pkt),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign id_valid = !buf_empty;
    assign id_pc    = head_pkt.pc;
    assign id_inst  = head_pkt.inst;

    assign req_allow = ((32'(buf_count) + 32'(pend_count)) < DEPTH) && !pend_full;

    // Reads still outstanding after this cycle; on flush every one of them is
    // stale. Already-squashed reads are part of this count, so the squash
    // total is replaced rather than added to, which keeps back-to-back
    // flushes from double counting.
    assign outst_next = {1'b0, pend_count} + (PEND_CW+1)'(req_fire)
                        - (PEND_CW+1)'(inst_resp);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            squash_cnt <= '0;
        end else if (flush) begin
            squash_cnt <= outst_next[PEND_CW-1:0];
        end else if (inst_resp && (squash_cnt != '0)) begin
            squash_cnt <= squash_cnt - 1'b1;
        end
    end

    a_fire_allowed: assert property (@(posedge clk) disable iff (!rst)
        !(req_fire && !req_allow));
    a_resp_pending: assert property (@(posedge clk) disable iff (!rst)
        !(inst_resp && pend_empty));
    a_buf_no_ovf:   assert property (@(posedge clk) disable iff (!rst)
        !(buf_push && buf_full && !buf_pop));

endmodule
